// File: rtl/gpio_board_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gpio_board_pkg
// Purpose  : Shared constants for the GPIO board I/O block: gpio_in field
//            layout, digit count and the hex-to-7-segment glyph table.
// Revision : 1.0  initial release
// ============================================================================
package gpio_board_pkg;

    localparam int SW_LSB     = 0;
    localparam int KEY_LSB    = 18;
    localparam int SW_W       = 18;
    localparam int KEY_W      = 4;
    localparam int NUM_DIGITS = 8;
    localparam int DIG_W      = $clog2(NUM_DIGITS);

    typedef logic [6:0] seg_t;

    // Raw board inputs as they enter the synchronizer, key_n kept active-low.
    typedef struct packed {
        logic [KEY_W-1:0] key_n;
        logic [SW_W-1:0]  sw;
    } board_in_t;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}.
    localparam seg_t HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
        7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
    };

    function automatic seg_t hex_seg(input logic [3:0] nib);
        return HEX_SEG[nib];
    endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_board_io_if.sv
`default_nettype none
// ============================================================================
// Module   : gpio_board_io_if
// Purpose  : Board-side bundle of the GPIO block: CPU GPIO words, switches,
//            pushbuttons and 7-segment display drive.
// Revision : 1.0  initial release
// ============================================================================
interface gpio_board_io_if;
    import gpio_board_pkg::*;

    logic [31:0]         gpio_out;
    logic [31:0]         gpio_in;
    logic [SW_W-1:0]     sw;
    logic [KEY_W-1:0]    key_n;
    seg_t                seg_n;
    logic [NUM_DIGITS-1:0] dig_sel_n;

    modport master (
        output gpio_out, sw, key_n,
        input  gpio_in, seg_n, dig_sel_n
    );

    modport slave (
        input  gpio_out, sw, key_n,
        output gpio_in, seg_n, dig_sel_n
    );

endinterface
`default_nettype wire

// File: rtl/gpio_board_debounce.sv
`default_nettype none
// ============================================================================
// Module   : gpio_board_debounce
// Purpose  : 2-flop synchronizer plus tick-sampled debouncer for WIDTH bits.
//            Debounce logic present only with GPIO_BOARD_DEBOUNCE_EN defined;
//            otherwise the synchronized level is passed straight through.
// Revision : 1.0  initial release
// ============================================================================
module gpio_board_debounce #(
    parameter int               WIDTH      = 22,
    parameter int               DEB_CYCLES = 250000,
    parameter logic [WIDTH-1:0] RST_VAL    = '0
) (
    input  wire               clk,
    input  wire               rst,
    input  wire [WIDTH-1:0]   i_async,
    output logic [WIDTH-1:0]  o_level
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= RST_VAL;
            r_sync2 <= RST_VAL;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
        end
    end

`ifdef GPIO_BOARD_DEBOUNCE_EN
    localparam int c_CNT_W = $clog2(DEB_CYCLES);

    logic [c_CNT_W-1:0] r_tick_cnt;
    logic [WIDTH-1:0]   r_samp;
    logic [WIDTH-1:0]   r_db;
    logic               w_tick;
    logic [WIDTH-1:0]   w_stable;

    always_comb begin
        w_tick   = (r_tick_cnt == c_CNT_W'(DEB_CYCLES - 1));
        w_stable = ~(r_sync2 ^ r_samp);
    end

    // A bit follows its sample only once two consecutive ticks agree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= '0;
            r_samp     <= RST_VAL;
            r_db       <= RST_VAL;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
            r_samp     <= r_sync2;
            r_db       <= (w_stable & r_sync2) | (~w_stable & r_db);
        end else begin
            r_tick_cnt <= r_tick_cnt + c_CNT_W'(1);
        end
    end

    assign o_level = r_db;
`else
    assign o_level = r_sync2;
`endif

endmodule
`default_nettype wire

// File: rtl/gpio_board_io.sv
`default_nettype none
// ============================================================================
// Module   : gpio_board_io
// Purpose  : Switch/key input port and 8-digit multiplexed hex display for a
//            CPU GPIO block. Debounce enabled by GPIO_BOARD_DEBOUNCE_EN.
// Revision : 1.0  initial release
// ============================================================================
module gpio_board_io
    import gpio_board_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int DEB_CYCLES = 250000
) (
    input  wire             clk,
    input  wire             rst,
    gpio_board_io_if.slave  bus
);

    localparam int c_SCAN_W = $clog2(SCAN_DIV);
    localparam board_in_t c_IN_RST = '{key_n: '1, sw: '0};

    board_in_t              w_raw;
    board_in_t              w_level;
    logic [31:0]            w_gpio_in;

    logic [c_SCAN_W-1:0]    r_scan_cnt;
    logic [DIG_W-1:0]       r_digit;
    logic [31:0]            r_disp;
    logic [31:0]            r_gpio_in;
    seg_t                   r_seg_n;
    logic [NUM_DIGITS-1:0]  r_dig_sel_n;

    logic                   w_wrap;
    logic [c_SCAN_W-1:0]    w_scan_nxt;
    logic [DIG_W-1:0]       w_digit_nxt;
    logic [31:0]            w_disp_nxt;
    logic [3:0]             w_nibble;

    assign w_raw = '{key_n: bus.key_n, sw: bus.sw};

    gpio_board_debounce #(
        .WIDTH      ($bits(board_in_t)),
        .DEB_CYCLES (DEB_CYCLES),
        .RST_VAL    (c_IN_RST)
    ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .i_async (w_raw),
        .o_level (w_level)
    );

    always_comb begin
        w_gpio_in                     = '0;
        w_gpio_in[SW_LSB +: SW_W]     = w_level.sw;
        w_gpio_in[KEY_LSB +: KEY_W]   = ~w_level.key_n;
    end

    // Outputs are computed from next-state so they line up with the counters.
    always_comb begin
        w_wrap      = (r_scan_cnt == c_SCAN_W'(SCAN_DIV - 1));
        w_scan_nxt  = w_wrap ? '0 : r_scan_cnt + c_SCAN_W'(1);
        w_digit_nxt = w_wrap ? r_digit + DIG_W'(1) : r_digit;
        w_disp_nxt  = (w_wrap && r_digit == DIG_W'(NUM_DIGITS - 1)) ? bus.gpio_out : r_disp;
        w_nibble    = w_disp_nxt[4*w_digit_nxt +: 4];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan_cnt  <= '0;
            r_digit     <= '0;
            r_disp      <= '0;
            r_gpio_in   <= '0;
            r_seg_n     <= 7'h7F;
            r_dig_sel_n <= '1;
        end else begin
            r_scan_cnt <= w_scan_nxt;
            r_digit    <= w_digit_nxt;
            r_disp     <= w_disp_nxt;
            r_gpio_in  <= w_gpio_in;
            // Segments switch only while every digit is blanked.
            if (w_scan_nxt == '0) begin
                r_dig_sel_n <= '1;
                r_seg_n     <= hex_seg(w_nibble);
            end else begin
                r_dig_sel_n <= ~(NUM_DIGITS'(1) << w_digit_nxt);
            end
        end
    end

    assign bus.gpio_in   = r_gpio_in;
    assign bus.seg_n     = r_seg_n;
    assign bus.dig_sel_n = r_dig_sel_n;

endmodule
`default_nettype wire

// File: doc/gpio_board_io.md
GPIO_BOARD_IO -- requirements
Module: gpio_board_io

Interface
REQ-001 Parameter SCAN_DIV, default 50000, meaning clocks per display digit slot (minimum 2).
REQ-002 Parameter DEB_CYCLES, default 250000, meaning clocks between debounce samples (minimum 2).
REQ-003 clk  input  1  clock.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 gpio_out  input  32  CPU GPIO output word, synchronous to clk.
REQ-006 sw  input  18  board slide switches, asynchronous.
REQ-007 key_n  input  4  board pushbuttons, asynchronous, active-low.
REQ-008 gpio_in  output  32  registered word to CPU GPIO input.
REQ-009 seg_n  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-010 dig_sel_n  output  8  active-low digit enables, bit i = digit i (digit 0 rightmost).

Function
REQ-011 gpio_in SHALL be {10'b0, key_db[3:0], sw_db[17:0]}; key_db is active-high (pressed = 1).
REQ-012 Every sw/key_n bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 A shared tick counter SHALL count 0..DEB_CYCLES-1 and wrap; a tick is asserted on the wrap cycle.
REQ-014 On each tick, each synchronized bit SHALL be sampled; the debounced bit SHALL update only when the current sample equals the previous tick's sample.
REQ-015 A pulse or glitch shorter than DEB_CYCLES clocks SHALL never reach gpio_in; a stable change SHALL reach gpio_in within 2*DEB_CYCLES+3 clocks.
REQ-016 A scan counter SHALL count 0..SCAN_DIV-1; on its wrap, the digit index SHALL advance 0→1→…→7→0.
REQ-017 disp_reg SHALL load gpio_out only on the clock where the digit index wraps 7→0; between loads gpio_out changes SHALL NOT affect the display (no tearing within a frame).
REQ-018 Digit i SHALL display hex nibble disp_reg[4i+3:4i] using standard hex glyphs (0-9, A, b, C, d, E, F).
REQ-019 dig_sel_n SHALL be 8'hFF during scan count 0 of every slot (anti-ghost blank), and ~(1<<index) for counts 1..SCAN_DIV-1.
REQ-020 seg_n and dig_sel_n SHALL be registered; seg_n SHALL change only on the blank cycle.

Reset
REQ-021 On rst: gpio_in=0, disp_reg=0, digit index=0, scan/tick counters=0, seg_n=7'h7F, dig_sel_n=8'hFF.
REQ-022 key_n synchronizer and sample flops SHALL reset to 1 (released) so that no spurious press follows reset; sw flops reset to 0.
REQ-023 rst asserted mid-frame or mid-debounce SHALL abandon all state immediately; the first frame after release SHALL start at digit 0 with disp_reg=0.

Configuration
REQ-024 Macro GPIO_BOARD_DEBOUNCE_EN defined: debounce per REQ-013..015 in force.
REQ-025 Macro undefined: the tick counter and sample flops SHALL be absent; gpio_in SHALL register the synchronized bits directly, with a sw/key change visible exactly 3 clocks later.

Structure
REQ-026 Package gpio_board_pkg SHALL hold the 16-entry hex-to-segment constant table, the gpio_in field offsets (SW_LSB=0, KEY_LSB=18), and digit count (8).
REQ-027 Sub-module gpio_board_debounce SHALL hold the synchronizer, tick counter and sample logic for a parameterized bit width; the top instantiates it once for 22 bits.

Verification (bench: SCAN_DIV=4, DEB_CYCLES=8)
REQ-028 Assert rst mid-frame -> same cycle seg_n=7'h7F, dig_sel_n=8'hFF, gpio_in=0; after release, first non-blank slot selects dig_sel_n=8'hFE.
REQ-029 gpio_out=32'h01234567 held for 2 frames -> digit 0 slot: dig_sel_n=8'hFE, seg_n=7'b1111000 ("7"); digit 7 slot: dig_sel_n=8'h7F, seg_n=7'b1000000 ("0").
REQ-030 gpio_out 0→32'hFFFFFFFF during digit 3 slot -> digits 4..7 still show "0" (7'b1000000); next frame all digits show "F" (7'b0001110).
REQ-031 With macro: sw=18'h2A5A5 held -> gpio_in[17:0]=18'h2A5A5 within 19 clocks; 3-clock high glitch on sw[0] -> gpio_in[0] never changes.
REQ-032 key_n=4'b1110 held -> gpio_in[21:18]=4'b0001, gpio_in[31:22]=0.
REQ-033 Without macro: sw 0→18'h00001 -> gpio_in[0]=1 exactly 3 clocks after the change is sampled.
